// File: rtl/ddr_bw_seq.sv
// DDR bandwidth sequencer: runs a small program of READ/WRITE burst commands against DDR engines.
// Latency: START to start pulse is 3 cycles (2-flop sync + IDLE); each instruction costs 3 cycles plus burst wait.
// Backpressure: each burst holds in its WAIT state until the engine reports idle; only one burst is in flight.
// Optional LOOP opcode is enabled by defining DDR_BW_SEQ_LOOP_EN; the default build treats opcode 0x03 as illegal.
module ddr_bw_seq #(
    parameter int PMEM_N   = 10,
    parameter int NBURST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PMEM_N-1:0] pmem_addr,
    input  logic [63:0]       pmem_do,
    input  logic [31:0]       DDR_BASEADDR_REG,
    input  logic              START_REG,
    output logic              RSTART_REG,
    output logic [31:0]       RADDR_REG,
    output logic [31:0]       RNBURST_REG,
    input  logic              RIDLE_REG,
    output logic              WSTART_REG,
    output logic [31:0]       WADDR_REG,
    output logic [31:0]       WNBURST_REG,
    input  logic              WIDLE_REG,
    output logic              start,
    output logic              done,
    output logic              err,
    output logic [31:0]       cycles,
    output logic [31:0]       rd_bursts,
    output logic [31:0]       wr_bursts
);

    // pc indexes 64-bit instructions, so it is three bits narrower than the byte address
    localparam int PC_W = PMEM_N - 3;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_LOOP  = 8'h03;
    localparam logic [7:0] OP_END   = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PC_RST,
        S_FETCH_WAIT,
        S_FETCH,
        S_DECODE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_ERR,
        S_END
    } state_t;

    state_t          state_q;
    logic [1:0]      start_sync_q;
    logic            start_seen;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc_d;
    logic            pc_wrap_q;
    logic [63:0]     instr_q;

    logic            start_q;
    logic            done_q;
    logic            err_q;
    logic            rstart_q;
    logic [31:0]     raddr_q;
    logic [31:0]     rnburst_q;
    logic            wstart_q;
    logic [31:0]     waddr_q;
    logic [31:0]     wnburst_q;
    logic [31:0]     rd_bursts_q;
    logic [31:0]     wr_bursts_q;
    logic [31:0]     cycles_q;
    logic [31:0]     cycles_d;

    // Decoded fields of the latched instruction
    logic [7:0]      op_w;
    logic [31:0]     addr_d;
    logic [31:0]     nburst_d;
    logic            nburst_zero;
    logic            unused_instr_bits;

    assign op_w        = instr_q[63:56];
    assign addr_d      = instr_q[55:24] + DDR_BASEADDR_REG;
    assign nburst_d    = {{(32 - NBURST_W){1'b0}}, instr_q[8 +: NBURST_W]};
    assign nburst_zero = (nburst_d == 32'd0);
    assign pc_inc_d    = pc_q + PC_W'(1);
    assign unused_instr_bits = ^{instr_q[7:0], instr_q[23:8]};

`ifdef DDR_BW_SEQ_LOOP_EN
    // Single loop level: counter holds the remaining extra passes once active
    logic            loop_act_q;
    logic [31:0]     loop_cnt_q;
    logic [31:0]     loop_count_w;
    logic [PC_W-1:0] loop_tgt_w;

    assign loop_count_w = instr_q[55:24];
    assign loop_tgt_w   = PC_W'(instr_q[23:8]);
`endif

    // Cycle counter stops at all-ones instead of wrapping
    assign cycles_d = (&cycles_q) ? cycles_q : (cycles_q + 32'd1);

    // Two-flop synchronizer for the asynchronous START request; flushed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            start_sync_q <= 2'b00;
        end else begin
            start_sync_q <= {start_sync_q[0], START_REG};
        end
    end

    assign start_seen = start_sync_q[1];

    // Run-cycle measurement: cleared when a run begins, counts while the program is active
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= 32'd0;
        end else if (state_q == S_PC_RST) begin
            cycles_q <= 32'd0;
        end else if (state_q != S_IDLE && state_q != S_END) begin
            cycles_q <= cycles_d;
        end
    end

    // Sequencer FSM with registered strobes, burst descriptors and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            pc_wrap_q   <= 1'b0;
            instr_q     <= 64'd0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rstart_q    <= 1'b0;
            raddr_q     <= 32'd0;
            rnburst_q   <= 32'd0;
            wstart_q    <= 1'b0;
            waddr_q     <= 32'd0;
            wnburst_q   <= 32'd0;
            rd_bursts_q <= 32'd0;
            wr_bursts_q <= 32'd0;
`ifdef DDR_BW_SEQ_LOOP_EN
            loop_act_q  <= 1'b0;
            loop_cnt_q  <= 32'd0;
`endif
        end else begin
            // Strobes are single-cycle unless re-armed below
            start_q  <= 1'b0;
            rstart_q <= 1'b0;
            wstart_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_seen) begin
                        start_q <= 1'b1;
                        state_q <= S_PC_RST;
                    end
                end

                S_PC_RST: begin
                    pc_q        <= '0;
                    pc_wrap_q   <= 1'b0;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    rd_bursts_q <= 32'd0;
                    wr_bursts_q <= 32'd0;
`ifdef DDR_BW_SEQ_LOOP_EN
                    loop_act_q  <= 1'b0;
                    loop_cnt_q  <= 32'd0;
`endif
                    state_q     <= S_FETCH_WAIT;
                end

                // pmem_addr is presented here; a wrapped pc means the program ran off the end
                S_FETCH_WAIT: begin
                    if (pc_wrap_q) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    instr_q <= pmem_do;
                    pc_q    <= pc_inc_d;
                    if (&pc_q) begin
                        pc_wrap_q <= 1'b1;
                    end
                    state_q <= S_DECODE;
                end

                S_DECODE: begin
                    case (op_w)
                        OP_READ: begin
                            if (nburst_zero) begin
                                state_q <= S_FETCH_WAIT;
                            end else begin
                                rstart_q  <= 1'b1;
                                raddr_q   <= addr_d;
                                rnburst_q <= nburst_d;
                                state_q   <= S_RD_ISSUE;
                            end
                        end
                        OP_WRITE: begin
                            if (nburst_zero) begin
                                state_q <= S_FETCH_WAIT;
                            end else begin
                                wstart_q  <= 1'b1;
                                waddr_q   <= addr_d;
                                wnburst_q <= nburst_d;
                                state_q   <= S_WR_ISSUE;
                            end
                        end
`ifdef DDR_BW_SEQ_LOOP_EN
                        OP_LOOP: begin
                            state_q <= S_FETCH_WAIT;
                            if (!loop_act_q) begin
                                if (loop_count_w != 32'd0) begin
                                    loop_cnt_q <= loop_count_w - 32'd1;
                                    loop_act_q <= 1'b1;
                                    pc_q       <= loop_tgt_w;
                                    pc_wrap_q  <= 1'b0;
                                end
                            end else if (loop_cnt_q != 32'd0) begin
                                loop_cnt_q <= loop_cnt_q - 32'd1;
                                pc_q       <= loop_tgt_w;
                                pc_wrap_q  <= 1'b0;
                            end else begin
                                loop_act_q <= 1'b0;
                            end
                        end
`endif
                        OP_END: begin
                            done_q  <= 1'b1;
                            state_q <= S_END;
                        end
                        default: begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    endcase
                end

                S_RD_ISSUE: begin
                    rd_bursts_q <= rd_bursts_q + rnburst_q;
                    state_q     <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (RIDLE_REG) begin
                        state_q <= S_FETCH_WAIT;
                    end
                end

                S_WR_ISSUE: begin
                    wr_bursts_q <= wr_bursts_q + wnburst_q;
                    state_q     <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (WIDLE_REG) begin
                        state_q <= S_FETCH_WAIT;
                    end
                end

                S_ERR: begin
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_END;
                end

                S_END: begin
                    done_q <= 1'b1;
                    if (!start_seen) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pmem_addr   = {pc_q, 3'b000};
    assign start       = start_q;
    assign done        = done_q;
    assign err         = err_q;
    assign RSTART_REG  = rstart_q;
    assign RADDR_REG   = raddr_q;
    assign RNBURST_REG = rnburst_q;
    assign WSTART_REG  = wstart_q;
    assign WADDR_REG   = waddr_q;
    assign WNBURST_REG = wnburst_q;
    assign cycles      = cycles_q;
    assign rd_bursts   = rd_bursts_q;
    assign wr_bursts   = wr_bursts_q;

endmodule

// File: tb/tb_ddr_bw_seq.sv
// Directed bench for ddr_bw_seq: small synchronous program memory plus read/write engine responders.
// Expected values are hand-derived from the instruction programs loaded below.
// PMEM_N=6 gives an 8-instruction program space so the overrun case is reachable.
module tb_ddr_bw_seq;

    localparam int PN = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [PN-1:0] pmem_addr;
    logic [63:0]   pmem_do;
    logic [31:0]   DDR_BASEADDR_REG;
    logic          START_REG;
    logic          RSTART_REG;
    logic [31:0]   RADDR_REG;
    logic [31:0]   RNBURST_REG;
    logic          RIDLE_REG = 1'b1;
    logic          WSTART_REG;
    logic [31:0]   WADDR_REG;
    logic [31:0]   WNBURST_REG;
    logic          WIDLE_REG = 1'b1;
    logic          start;
    logic          done;
    logic          err;
    logic [31:0]   cycles;
    logic [31:0]   rd_bursts;
    logic [31:0]   wr_bursts;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] mem [0:7];
    int rlat = 20;
    int wlat = 20;
    int rcnt = 0;
    int wcnt = 0;
    int rpulses = 0;
    int wpulses = 0;
    logic [31:0] raddr_late = 32'd0;
    logic [31:0] waddr_late = 32'd0;

    always #5 clk = ~clk;

    ddr_bw_seq #(.PMEM_N(PN), .NBURST_W(16)) dut (
        .clk(clk), .rst(rst), .pmem_addr(pmem_addr), .pmem_do(pmem_do),
        .DDR_BASEADDR_REG(DDR_BASEADDR_REG), .START_REG(START_REG),
        .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG), .RNBURST_REG(RNBURST_REG),
        .RIDLE_REG(RIDLE_REG),
        .WSTART_REG(WSTART_REG), .WADDR_REG(WADDR_REG), .WNBURST_REG(WNBURST_REG),
        .WIDLE_REG(WIDLE_REG),
        .start(start), .done(done), .err(err),
        .cycles(cycles), .rd_bursts(rd_bursts), .wr_bursts(wr_bursts)
    );

    // Program memory: registered read, data one cycle after the address
    always @(posedge clk) pmem_do <= mem[pmem_addr[PN-1:3]];

    // Read engine: busy for rlat cycles after each start pulse; records address at end of burst
    always @(posedge clk) begin
        if (RSTART_REG === 1'b1) begin
            rpulses   <= rpulses + 1;
            rcnt      <= rlat;
            RIDLE_REG <= 1'b0;
        end else if (rcnt > 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) begin
                RIDLE_REG  <= 1'b1;
                raddr_late <= RADDR_REG;
            end
        end
    end

    // Write engine, same behaviour
    always @(posedge clk) begin
        if (WSTART_REG === 1'b1) begin
            wpulses   <= wpulses + 1;
            wcnt      <= wlat;
            WIDLE_REG <= 1'b0;
        end else if (wcnt > 0) begin
            wcnt <= wcnt - 1;
            if (wcnt == 1) begin
                WIDLE_REG  <= 1'b1;
                waddr_late <= WADDR_REG;
            end
        end
    end

    function automatic logic [63:0] ins(input logic [7:0] op, input logic [31:0] off,
                                        input logic [15:0] nb);
        return {op, off, nb, 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 64'd0;
    endtask

    // Raise START until the start pulse appears, then drop it (the run must carry on regardless)
    task automatic start_run(input string tag);
        int n;
        n = 0;
        START_REG = 1'b1;
        while (start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, {31'd0, (n < 20)}, 32'd1);
        START_REG = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_run(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_time"}, {31'd0, (n < budget)}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int rp0;
        int wp0;
        int n;

        rst = 1'b1;
        START_REG = 1'b0;
        DDR_BASEADDR_REG = 32'h1000_0000;
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_rstart", {31'd0, RSTART_REG}, 32'd0);
        chk("rst_raddr", RADDR_REG, 32'd0);
        chk("rst_wnburst", WNBURST_REG, 32'd0);
        chk("rst_pmem_addr", {26'd0, pmem_addr}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_cycles", cycles, 32'd0);

        // Single READ then END; 20-cycle engine latency
        clear_mem();
        mem[0] = ins(8'h01, 32'h40, 16'd8);
        mem[1] = ins(8'h3F, 32'h0, 16'd0);
        rlat = 20;
        rp0 = rpulses; wp0 = wpulses;
        start_run("t1");
        finish_run("t1", 500);
        chk("t1_rpulses", rpulses - rp0, 32'd1);
        chk("t1_wpulses", wpulses - wp0, 32'd0);
        chk("t1_raddr", RADDR_REG, 32'h1000_0040);
        chk("t1_raddr_held", raddr_late, 32'h1000_0040);
        chk("t1_rnburst", RNBURST_REG, 32'd8);
        chk("t1_rd_bursts", rd_bursts, 32'd8);
        chk("t1_done_err", {30'd0, done, err}, 32'd2);
        // FW,F,D + ISSUE + 21 wait cycles + FW,F,D(END)
        chk("t1_cycles", cycles, 32'd28);

        // WRITE nb 4, READ nb 0 (skipped), END
        clear_mem();
        mem[0] = ins(8'h02, 32'h100, 16'd4);
        mem[1] = ins(8'h01, 32'h200, 16'd0);
        mem[2] = ins(8'h3F, 32'h0, 16'd0);
        wlat = 5;
        rp0 = rpulses; wp0 = wpulses;
        start_run("t2");
        finish_run("t2", 500);
        chk("t2_wpulses", wpulses - wp0, 32'd1);
        chk("t2_rpulses", rpulses - rp0, 32'd0);
        chk("t2_waddr", WADDR_REG, 32'h1000_0100);
        chk("t2_waddr_held", waddr_late, 32'h1000_0100);
        chk("t2_wnburst", WNBURST_REG, 32'd4);
        chk("t2_wr_bursts", wr_bursts, 32'd4);
        chk("t2_rd_bursts", rd_bursts, 32'd0);
        chk("t2_done_err", {30'd0, done, err}, 32'd2);

        // Illegal opcode 0x7E at pc 0
        clear_mem();
        mem[0] = ins(8'h7E, 32'h0, 16'd3);
        mem[1] = ins(8'h3F, 32'h0, 16'd0);
        rp0 = rpulses; wp0 = wpulses;
        start_run("t3");
        finish_run("t3", 100);
        chk("t3_pulses", (rpulses - rp0) + (wpulses - wp0), 32'd0);
        chk("t3_done_err", {30'd0, done, err}, 32'd3);
        chk("t3_wr_bursts", wr_bursts, 32'd0);
        // FW,F,D,ERR
        chk("t3_cycles", cycles, 32'd4);

`ifdef DDR_BW_SEQ_LOOP_EN
        // READ nb 2; LOOP count 3 target 0; END -> four passes
        clear_mem();
        mem[0] = ins(8'h01, 32'h0, 16'd2);
        mem[1] = ins(8'h03, 32'd3, 16'd0);
        mem[2] = ins(8'h3F, 32'h0, 16'd0);
        rlat = 3;
        rp0 = rpulses;
        start_run("t4");
        finish_run("t4", 1000);
        chk("t4_rpulses", rpulses - rp0, 32'd4);
        chk("t4_rd_bursts", rd_bursts, 32'd8);
        chk("t4_done_err", {30'd0, done, err}, 32'd2);
`else
        // Opcode 0x03 is illegal in this build
        clear_mem();
        mem[0] = ins(8'h03, 32'd3, 16'd0);
        mem[1] = ins(8'h3F, 32'h0, 16'd0);
        rp0 = rpulses; wp0 = wpulses;
        start_run("t4");
        finish_run("t4", 100);
        chk("t4_pulses", (rpulses - rp0) + (wpulses - wp0), 32'd0);
        chk("t4_done_err", {30'd0, done, err}, 32'd3);
`endif

        // No END: eight READ nb 1 then pc overrun; address wraps mod 2^32; cycles saturate
        DDR_BASEADDR_REG = 32'hFFFF_FFF0;
        for (int i = 0; i < 8; i++) mem[i] = ins(8'h01, 32'h20, 16'd1);
        rlat = 3;
        rp0 = rpulses;
        start_run("t5");
        n = 0;
        while (rpulses == rp0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_first_read", {31'd0, (n < 50)}, 32'd1);
        force dut.cycles_q = 32'hFFFF_FFFD;
        @(negedge clk);
        release dut.cycles_q;
        finish_run("t5", 1000);
        chk("t5_rpulses", rpulses - rp0, 32'd8);
        chk("t5_rd_bursts", rd_bursts, 32'd8);
        chk("t5_raddr_wrap", RADDR_REG, 32'h0000_0010);
        chk("t5_done_err", {30'd0, done, err}, 32'd3);
        chk("t5_cycles_sat", cycles, 32'hFFFF_FFFF);

        // Reset during RD_WAIT, then a clean rerun
        DDR_BASEADDR_REG = 32'h1000_0000;
        clear_mem();
        mem[0] = ins(8'h01, 32'h0, 16'd5);
        mem[1] = ins(8'h3F, 32'h0, 16'd0);
        rlat = 20;
        rp0 = rpulses;
        start_run("t6a");
        n = 0;
        while (rpulses == rp0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_read", {31'd0, (n < 50)}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t6_wait_raddr", RADDR_REG, 32'h1000_0000);
        chk("t6_wait_pmem_addr", {26'd0, pmem_addr}, 32'd8);
        chk("t6_wait_rd_bursts", rd_bursts, 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_strobes", {28'd0, RSTART_REG, WSTART_REG, start, done}, 32'd0);
        chk("t6_rst_raddr", RADDR_REG, 32'd0);
        chk("t6_rst_rnburst", RNBURST_REG, 32'd0);
        chk("t6_rst_waddr", WADDR_REG, 32'd0);
        chk("t6_rst_pmem_addr", {26'd0, pmem_addr}, 32'd0);
        chk("t6_rst_counts", cycles | rd_bursts | wr_bursts, 32'd0);
        chk("t6_rst_err", {31'd0, err}, 32'd0);
        repeat (25) @(negedge clk);
        rp0 = rpulses;
        start_run("t6b");
        finish_run("t6b", 500);
        chk("t6_rerun_rpulses", rpulses - rp0, 32'd1);
        chk("t6_rerun_rd_bursts", rd_bursts, 32'd5);
        chk("t6_rerun_done_err", {30'd0, done, err}, 32'd2);
        chk("t6_rerun_cycles", cycles, 32'd28);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr_bw_seq.md
DDR_BW_SEQ -- requirements
Module: ddr_bw_seq

Interface
REQ-001 Parameter PMEM_N, default 10: program-memory byte-address width; the program holds 2^(PMEM_N-3) 64-bit instructions.
REQ-002 Parameter NBURST_W, default 16: burst-count field width, 1..16; instruction bits [23:8] are truncated to this width.
REQ-003 clk input 1: single clock; all logic is on its rising edge.
REQ-004 rst input 1: reset, synchronous and active-high.
REQ-005 pmem_addr output PMEM_N: instruction byte address, equal to pc*8.
REQ-006 pmem_do input 64: instruction word, valid one cycle after pmem_addr.
REQ-007 DDR_BASEADDR_REG input 32: base address added to every instruction offset.
REQ-008 START_REG input 1: run request; asynchronous; two-flop synchronized inside the block.
REQ-009 RSTART_REG, RADDR_REG, RNBURST_REG outputs 1/32/32: read-engine start pulse, address and burst count.
REQ-010 RIDLE_REG input 1: read engine idle.
REQ-011 WSTART_REG, WADDR_REG, WNBURST_REG outputs 1/32/32: write-engine start pulse, address and burst count.
REQ-012 WIDLE_REG input 1: write engine idle.
REQ-013 start output 1: one-cycle pulse at the beginning of a run.
REQ-014 done, err outputs 1/1: run finished; run ended on an illegal instruction or a pc overrun.
REQ-015 cycles, rd_bursts, wr_bursts outputs 32/32/32: measured run cycles; total read bursts issued; total write bursts issued.

Function
REQ-016 Instruction format: op=[63:56], offset=[55:24], nburst=[23:8]; the target address is offset+DDR_BASEADDR_REG mod 2^32.
REQ-017 Opcodes: 0x01 READ, 0x02 WRITE, 0x03 LOOP (see REQ-027), 0x3F END; every other opcode is illegal.
REQ-018 FSM states: IDLE, PC_RST, FETCH_WAIT, FETCH, DECODE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, ERR, END.
REQ-019 IDLE moves to PC_RST when synchronized START is 1; PC_RST sets pc=0 and pulses start.
REQ-020 PC_RST moves to FETCH_WAIT, then to FETCH. FETCH latches pmem_do into the instruction register and sets pc=pc+1. FETCH then moves to DECODE.
REQ-021 DECODE on READ/WRITE with nburst!=0 moves to RD_ISSUE/WR_ISSUE. DECODE on READ/WRITE with nburst==0 moves to FETCH_WAIT; no start pulse is issued.
REQ-022 RD_ISSUE drives RSTART_REG=1 for exactly one cycle and adds nburst to rd_bursts. RD_WAIT holds until RIDLE_REG=1, then moves to FETCH_WAIT. WR_ISSUE/WR_WAIT behave the same way using the W signals and WIDLE_REG.
REQ-023 R/WADDR_REG and R/WNBURST_REG (zero-extended) stay stable from the ISSUE state through the end of the WAIT state.
REQ-024 DECODE on an illegal opcode moves to ERR, which sets err=1 and moves to END. A fetch that would read past the last instruction (pc wraps to 0) also moves to ERR.
REQ-025 END sets done=1; when synchronized START is 0, END moves to IDLE. Deasserting START during a run has no effect until END is reached.
REQ-026 cycles clears in PC_RST, increments every cycle outside IDLE/END, and saturates at 0xFFFFFFFF. rd_bursts, wr_bursts, done and err clear in PC_RST.

Configuration
REQ-027 With DDR_BW_SEQ_LOOP_EN defined, LOOP uses count=[55:24] and target=[23:8] (instruction index). It uses a single loop counter:
- inactive and count==0: fall through.
- inactive and count!=0: load count-1, set active, pc=target.
- active and counter!=0: decrement, pc=target.
- active and counter==0: clear active, fall through.
REQ-028 Without DDR_BW_SEQ_LOOP_EN, opcode 0x03 is illegal, and no loop counter or loop-state logic is synthesized.

Reset
REQ-029 rst=1 forces IDLE at the next edge, including mid-burst. All outputs then read 0: strobes, addresses, counters, pc, done, err, start. The loop state also clears.
REQ-030 After rst the synchronizer is flushed, and a run requires START to be seen as 1 again.

Verification
REQ-031 Base 0x1000_0000, program {READ off 0x40 nb 8, END}, START=1, RIDLE_REG returns 1 after 20 cycles -> one RSTART_REG pulse with RADDR_REG=0x1000_0040 and RNBURST_REG=8; done=1, rd_bursts=8, err=0.
REQ-032 Program {WRITE nb 4, READ nb 0, END} -> one WSTART_REG pulse with WNBURST_REG=4; no RSTART_REG pulse; wr_bursts=4, rd_bursts=0.
REQ-033 Program {0x7E, ...} -> err=1 and done=1, with no start pulses; with LOOP_EN off, {0x03,...} gives the same result.
REQ-034 LOOP_EN on, program {READ nb 2, LOOP count 3 target 0, END} -> 4 RSTART_REG pulses and rd_bursts=8.
REQ-035 Program with no END (all READ nb 1, PMEM_N=6) -> 8 reads, then err=1; forcing cycles near 0xFFFFFFFF holds it at 0xFFFFFFFF.
REQ-036 rst pulsed during RD_WAIT -> next cycle is IDLE with every output 0; a following START runs the program cleanly from pc=0.
